// File: rtl/pacman_mover.sv
// pacman_mover: tile-grid movement controller for the Pac-Man sprite.
// Queries the legal-move lookup, applies turn requests, steps 1 px/tick.
// Ports: clk, rst_n (async low); tick move strobe; btn_l/r/u/d joystick;
//   q_x/q_y lookup query; leg_l/r/u/d lookup reply; xpos/ypos sprite;
//   cell_col/cell_row cell index; dir 0=L 1=R 2=U 3=D; moving;
//   cell_done centre-landing pulse; overrun sticky dropped-tick flag.
module pacman_mover #(
  parameter int SF         = 12,
  parameter int ORIGIN_X   = 150,
  parameter int ORIGIN_Y   = 34,
  parameter int COLS       = 28,
  parameter int START_COL  = 13,
  parameter int START_ROW  = 23,
  parameter int LOOKUP_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  input  logic       btn_d,
  output logic [9:0] q_x,
  output logic [9:0] q_y,
  input  logic       leg_l,
  input  logic       leg_r,
  input  logic       leg_u,
  input  logic       leg_d,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic [5:0] cell_col,
  output logic [5:0] cell_row,
  output logic [1:0] dir,
  output logic       moving,
  output logic       cell_done,
  output logic       overrun
);

  localparam int SW = $clog2(SF);

  localparam logic [9:0] X_RST = 10'(ORIGIN_X + START_COL * SF);
  localparam logic [9:0] Y_RST = 10'(ORIGIN_Y + START_ROW * SF);
  localparam logic [9:0] X_MIN = 10'(ORIGIN_X);
  localparam logic [9:0] X_MAX = 10'(ORIGIN_X + (COLS - 1) * SF);
  localparam logic [5:0] C_RST = 6'(START_COL);
  localparam logic [5:0] R_RST = 6'(START_ROW);
  localparam logic [5:0] C_MAX = 6'(COLS - 1);
  localparam logic [SW-1:0] SUB_MAX = SW'(SF - 1);
  localparam logic [1:0] LAT = 2'(LOOKUP_LAT);

  localparam logic [1:0] D_L = 2'd0;
  localparam logic [1:0] D_R = 2'd1;
  localparam logic [1:0] D_U = 2'd2;
  localparam logic [1:0] D_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE, WAIT, DECIDE, STEP
  } state_t;

  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic pend, pend_n, ovr_n;

  logic req_v;
  logic [1:0] req;

  logic [SW-1:0] sub_x, sub_y, nsx, nsy;
  logic [9:0] nx, ny;
  logic [5:0] ncol, nrow;

  logic [3:0] legs;
  logic aligned, wrap_l, wrap_r;

  assign q_x = xpos;
  assign q_y = ypos;
  assign legs = {leg_d, leg_u, leg_r, leg_l};
  assign aligned = (sub_x == '0) && (sub_y == '0);
  assign wrap_l = aligned && (cell_col == '0);
  assign wrap_r = aligned && (cell_col == C_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_v <= 1'b0;
      req   <= D_L;
    end else if (btn_l | btn_r | btn_u | btn_d) begin
      req_v <= 1'b1;
      priority case (1'b1)
        btn_l:   req <= D_L;
        btn_r:   req <= D_R;
        btn_u:   req <= D_U;
        default: req <= D_D;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pend    <= pend_n;
      overrun <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    ovr_n   = overrun;
    if (state != IDLE && tick) begin
      if (pend) ovr_n = 1'b1;
      else      pend_n = 1'b1;
    end
    unique case (state)
      IDLE: begin
        if (tick || pend) begin
          state_n = WAIT;
          cnt_n   = LAT;
          // a fresh tick alongside a serviced pending one stays queued
          pend_n  = pend && tick;
        end
      end
      WAIT: begin
        if (cnt == '0) state_n = DECIDE;
        else           cnt_n = cnt - 2'd1;
      end
      DECIDE: state_n = STEP;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    nx   = xpos;
    ny   = ypos;
    nsx  = sub_x;
    nsy  = sub_y;
    ncol = cell_col;
    nrow = cell_row;
    unique case (dir)
      D_L: begin
        if (wrap_l) begin
          nx   = X_MAX;
          nsx  = '0;
          ncol = C_MAX;
        end else begin
          nx = xpos - 10'd1;
          if (sub_x == '0) begin
            nsx  = SUB_MAX;
            ncol = cell_col - 6'd1;
          end else begin
            nsx = sub_x - SW'(1);
          end
        end
      end
      D_R: begin
        if (wrap_r) begin
          nx   = X_MIN;
          nsx  = '0;
          ncol = '0;
        end else begin
          nx = xpos + 10'd1;
          if (sub_x == SUB_MAX) begin
            nsx  = '0;
            ncol = cell_col + 6'd1;
          end else begin
            nsx = sub_x + SW'(1);
          end
        end
      end
      D_U: begin
        ny = ypos - 10'd1;
        if (sub_y == '0) begin
          nsy  = SUB_MAX;
          nrow = cell_row - 6'd1;
        end else begin
          nsy = sub_y - SW'(1);
        end
      end
      default: begin
        ny = ypos + 10'd1;
        if (sub_y == SUB_MAX) begin
          nsy  = '0;
          nrow = cell_row + 6'd1;
        end else begin
          nsy = sub_y + SW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xpos      <= X_RST;
      ypos      <= Y_RST;
      cell_col  <= C_RST;
      cell_row  <= R_RST;
      sub_x     <= '0;
      sub_y     <= '0;
      dir       <= D_L;
      moving    <= 1'b0;
      cell_done <= 1'b0;
    end else begin
      cell_done <= 1'b0;
      if (state == DECIDE) begin
        if (aligned) begin
          if (req_v && legs[req]) begin
            dir    <= req;
            moving <= 1'b1;
          end else begin
            moving <= legs[dir];
          end
        end else begin
          moving <= 1'b1;
          // L/R and U/D differ only in bit 0
          if (req_v && req == (dir ^ 2'd1)) dir <= req;
        end
      end
      // moving while aligned implies leg[dir], so wraps are legal here
      if (state == STEP && moving) begin
        xpos      <= nx;
        ypos      <= ny;
        sub_x     <= nsx;
        sub_y     <= nsy;
        cell_col  <= ncol;
        cell_row  <= nrow;
        cell_done <= (nsx == '0) && (nsy == '0);
      end
    end
  end

endmodule

// File: tb/tb_pacman_mover.sv
// tb_pacman_mover: directed + random bench for pacman_mover.
// Pixel-level reference model; lookup stub driven from q_x/q_y.
module tb_pacman_mover;

  localparam int SF   = 12;
  localparam int OX   = 150;
  localparam int OY   = 34;
  localparam int COLS = 28;
  localparam int LAT  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic leg_l, leg_r, leg_u, leg_d;
  logic [9:0] q_x, q_y, xpos, ypos;
  logic [5:0] cell_col, cell_row;
  logic [1:0] dir;
  logic moving, cell_done, overrun;

  int checks = 0;
  int failures = 0;
  int mode = 0;
  logic [3:0] man = 4'hF;
  int mx, my, mdir, mreq, mmv, mcd;
  int ncd;

  always #5 clk = ~clk;

  pacman_mover #(
    .SF(SF), .ORIGIN_X(OX), .ORIGIN_Y(OY), .COLS(COLS),
    .START_COL(13), .START_ROW(23), .LOOKUP_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .q_x(q_x), .q_y(q_y),
    .leg_l(leg_l), .leg_r(leg_r), .leg_u(leg_u), .leg_d(leg_d),
    .xpos(xpos), .ypos(ypos),
    .cell_col(cell_col), .cell_row(cell_row),
    .dir(dir), .moving(moving),
    .cell_done(cell_done), .overrun(overrun)
  );

  // maze-like legality confined to cols 0..27, rows 1..29; row 14 tunnels
  function automatic logic [3:0] grid(input int c, input int r);
    logic l, rr, u, d;
    l  = (c > 0 || r == 14) && ((c + r) % 3 != 0);
    rr = (c < COLS - 1 || r == 14) && ((2 * c + r) % 4 != 1);
    u  = (r > 1) && ((c + 3 * r) % 5 != 2);
    d  = (r < 29) && ((3 * c + r) % 5 != 4);
    if (!(l || rr || u || d)) begin
      u = (r > 1);
      d = (r < 29);
    end
    return {d, u, rr, l};
  endfunction

  function automatic logic [3:0] legs_at(input int md, input logic [3:0] mn,
                                         input int x, input int y);
    if (md == 0) return 4'hF;
    if (md == 1) return mn;
    return grid((x - OX) / SF, (y - OY) / SF);
  endfunction

  assign {leg_d, leg_u, leg_r, leg_l} =
    legs_at(mode, man, int'(q_x), int'(q_y));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    checks++;
    assert (got === 32'(exp)) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_init();
    mx = OX + 13 * SF;
    my = OY + 23 * SF;
    mdir = 0;
    mreq = -1;
    mmv = 0;
    mcd = 0;
  endtask

  task automatic model_step();
    logic [3:0] lg;
    int col;
    bit al;
    lg = legs_at(mode, man, mx, my);
    col = (mx - OX) / SF;
    al = ((mx - OX) % SF == 0) && ((my - OY) % SF == 0);
    if (al) begin
      if (mreq >= 0 && lg[2'(mreq)]) begin
        mdir = mreq;
        mmv = 1;
      end else begin
        mmv = lg[2'(mdir)] ? 1 : 0;
      end
    end else begin
      mmv = 1;
      if ((mdir == 0 && mreq == 1) || (mdir == 1 && mreq == 0) ||
          (mdir == 2 && mreq == 3) || (mdir == 3 && mreq == 2))
        mdir = mreq;
    end
    mcd = 0;
    if (mmv == 1) begin
      case (mdir)
        0: mx = (al && col == 0) ? OX + (COLS - 1) * SF : mx - 1;
        1: mx = (al && col == COLS - 1) ? OX : mx + 1;
        2: my = my - 1;
        default: my = my + 1;
      endcase
      mcd = ((mx - OX) % SF == 0 && (my - OY) % SF == 0) ? 1 : 0;
    end
  endtask

  task automatic check_all();
    chk("xpos", 32'(xpos), mx);
    chk("q_x", 32'(q_x), mx);
    chk("ypos", 32'(ypos), my);
    chk("q_y", 32'(q_y), my);
    chk("cell_col", 32'(cell_col), (mx - OX) / SF);
    chk("cell_row", 32'(cell_row), (my - OY) / SF);
    chk("dir", 32'(dir), mdir);
    chk("moving", 32'(moving), mmv);
    chk("cell_done", 32'(cell_done), mcd);
  endtask

  task automatic chk_reset();
    chk("rst_xpos", 32'(xpos), 306);
    chk("rst_ypos", 32'(ypos), 310);
    chk("rst_col", 32'(cell_col), 13);
    chk("rst_row", 32'(cell_row), 23);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_moving", 32'(moving), 0);
    chk("rst_cd", 32'(cell_done), 0);
    chk("rst_overrun", 32'(overrun), 0);
  endtask

  task automatic press(input logic [3:0] m);
    {btn_d, btn_u, btn_r, btn_l} = m;
    cyc();
    {btn_d, btn_u, btn_r, btn_l} = 4'b0000;
    if (m[0])      mreq = 0;
    else if (m[1]) mreq = 1;
    else if (m[2]) mreq = 2;
    else if (m[3]) mreq = 3;
  endtask

  task automatic do_tick();
    cyc();
    chk("cd_clear", 32'(cell_done), 0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    repeat (LAT + 3) cyc();
    model_step();
    check_all();
  endtask

  initial begin
    model_init();
    repeat (2) cyc();
    chk_reset();
    rst_n = 1'b1;
    cyc();
    check_all();

    // first step: exact four-cycle tick-to-position latency
    press(4'b0010);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    repeat (LAT + 2) cyc();
    chk("lat_early", 32'(xpos), 306);
    cyc();
    model_step();
    check_all();
    chk("first_x", 32'(xpos), 307);
    chk("first_mv", 32'(moving), 1);
    ncd = int'(cell_done);

    for (int i = 0; i < 11; i++) begin
      do_tick();
      ncd += int'(cell_done);
    end
    chk("cd_count", ncd, 1);
    chk("x12", 32'(xpos), 318);
    chk("col12", 32'(cell_col), 14);

    // blocked at centre: req R illegal, dir R illegal -> stop
    mode = 1;
    man = 4'b0100;
    do_tick();
    chk("blk_mv", 32'(moving), 0);
    chk("blk_x", 32'(xpos), 318);
    press(4'b0100);
    do_tick();
    chk("turn_u", 32'(ypos), 309);

    // reversal mid-tile, perpendicular request deferred to centre
    mode = 0;
    press(4'b1000);
    do_tick();
    press(4'b0010);
    repeat (5) do_tick();
    chk("mid_x", 32'(xpos), 323);
    press(4'b0001);
    do_tick();
    chk("rev_x", 32'(xpos), 322);
    press(4'b0100);
    do_tick();
    chk("defer_dir", 32'(dir), 0);
    repeat (3) do_tick();
    chk("centre_x", 32'(xpos), 318);
    do_tick();
    chk("late_turn", 32'(dir), 2);

    // run to column 0 and through the tunnel both ways
    press(4'b1000);
    do_tick();
    press(4'b0001);
    for (int i = 0; i < 200 && mx != OX; i++) do_tick();
    chk("reach_c0", 32'(xpos), OX);
    do_tick();
    chk("wrap_x", 32'(xpos), 474);
    chk("wrap_col", 32'(cell_col), 27);
    chk("wrap_cd", 32'(cell_done), 1);
    press(4'b0010);
    do_tick();
    chk("wrapr_x", 32'(xpos), OX);
    chk("wrapr_cd", 32'(cell_done), 1);

    // random walk over the maze stub
    mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) press(4'($urandom_range(0, 15)));
      do_tick();
    end

    // back-to-back ticks: one serviced, one pending, one dropped
    mode = 0;
    cyc();
    chk("ovr_pre", 32'(overrun), 0);
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    chk("ovr_set", 32'(overrun), 1);
    repeat (2) cyc();
    model_step();
    check_all();
    chk("ovr_sticky", 32'(overrun), 1);
    cyc();
    rst_n = 1'b0;
    #1;
    model_init();
    chk_reset();
    cyc();
    rst_n = 1'b1;
    repeat (8) cyc();
    chk("no_pend_x", 32'(xpos), 306);
    do_tick();
    chk("post_rst_x", 32'(xpos), 305);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
